// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubble insertion and MDU stall control with saturating stall counter.
// Optional MDU_WAIT timeout abort enabled by defining HZ_MDU_TIMEOUT_EN.
module hazard_stall_ctrl #(
    parameter int GPR_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 16,
    parameter int MDU_TIMEOUT     = 40
) (
    input  logic                       hz_clk,
    input  logic                       hz_rst,
    input  logic                       wdt_reset_i,
    input  logic [GPR_ADDR_WIDTH-1:0]  id_rs1,
    input  logic [GPR_ADDR_WIDTH-1:0]  id_rs2,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [GPR_ADDR_WIDTH-1:0]  ex_rd,
    input  logic                       ex_mem_rd_en,
    input  logic                       mdu_start_i,
    input  logic                       mult_valid_i,
    input  logic                       div_valid_i,
    input  logic                       rem_valid_i,
    input  logic                       branch_flush_i,
    output logic                       stall_pipeline,
    output logic                       flush_id_ex,
    output logic [1:0]                 hz_state_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles_o,
    output logic                       mdu_timeout_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, LU_STALL = 2'b01, MDU_WAIT = 2'b10, MDU_DRAIN = 2'b11} state_t;
    state_t                     state_q, state_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                       load_use, any_valid, stall_d, flush_d, timeout;

    assign load_use  = ex_mem_rd_en && (ex_rd != '0) &&
                       ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    assign any_valid = mult_valid_i || div_valid_i || rem_valid_i;

`ifdef HZ_MDU_TIMEOUT_EN
    localparam int TW = $clog2(MDU_TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    // Counter is zero outside MDU_WAIT, so it restarts on every entry.
    assign to_cnt_d = (state_q == MDU_WAIT) ? to_cnt_q + 1'b1 : '0;
    assign timeout  = (state_q == MDU_WAIT) && (to_cnt_q == TW'(MDU_TIMEOUT - 1)) && !any_valid;
    always_ff @(posedge hz_clk or negedge hz_rst) begin
        if (!hz_rst) to_cnt_q <= '0;
        else         to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        flush_d = 1'b0;
        if (wdt_reset_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (branch_flush_i) begin
                        flush_d = 1'b1;
                    end else if (mdu_start_i) begin
                        stall_d = 1'b1;
                        state_d = MDU_WAIT;
                    end else if (load_use) begin
                        stall_d = 1'b1;
                        flush_d = 1'b1;
                        state_d = LU_STALL;
                    end
                end
                LU_STALL: begin
                    flush_d = branch_flush_i;
                    state_d = IDLE;
                end
                MDU_WAIT: begin
                    stall_d = 1'b1;
                    state_d = any_valid ? MDU_DRAIN : (timeout ? IDLE : MDU_WAIT);
                end
                MDU_DRAIN: begin
                    stall_d = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign stall_cnt_d = wdt_reset_i ? '0 :
                         (stall_d && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    always_ff @(posedge hz_clk or negedge hz_rst) begin
        if (!hz_rst) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Mealy outputs gated by reset so they drop the instant hz_rst falls.
    assign stall_pipeline = hz_rst && stall_d;
    assign flush_id_ex    = hz_rst && flush_d;
    assign mdu_timeout_o  = hz_rst && timeout && !wdt_reset_i;
    assign hz_state_o     = state_q;
    assign stall_cycles_o = stall_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed self-checking bench for hazard_stall_ctrl (6-bit stall counter to reach saturation).
module tb_hazard_stall_ctrl;
    logic       hz_clk = 1'b0, hz_rst, wdt_reset_i;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_rd_en, mdu_start_i;
    logic       mult_valid_i, div_valid_i, rem_valid_i, branch_flush_i;
    logic       stall_pipeline, flush_id_ex, mdu_timeout_o;
    logic [1:0] hz_state_o;
    logic [5:0] stall_cycles_o;
    int         checks = 0, errors = 0;

    hazard_stall_ctrl #(.GPR_ADDR_WIDTH(5), .STALL_CNT_WIDTH(6), .MDU_TIMEOUT(40)) dut (
        .hz_clk(hz_clk), .hz_rst(hz_rst), .wdt_reset_i(wdt_reset_i),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_rd_en(ex_mem_rd_en), .mdu_start_i(mdu_start_i),
        .mult_valid_i(mult_valid_i), .div_valid_i(div_valid_i), .rem_valid_i(rem_valid_i),
        .branch_flush_i(branch_flush_i), .stall_pipeline(stall_pipeline), .flush_id_ex(flush_id_ex),
        .hz_state_o(hz_state_o), .stall_cycles_o(stall_cycles_o), .mdu_timeout_o(mdu_timeout_o)
    );

    always #5 hz_clk = ~hz_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge hz_clk);
        #1;
    endtask

    task automatic clr;
        {wdt_reset_i, id_rs1_used, id_rs2_used, ex_mem_rd_en, mdu_start_i} = '0;
        {mult_valid_i, div_valid_i, rem_valid_i, branch_flush_i} = '0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    endtask

    initial begin
        clr();
        hz_rst = 1'b0;
        mdu_start_i = 1'b1;
        #2;
        chk("rst_stall", stall_pipeline, 0);
        chk("rst_flush", flush_id_ex, 0);
        chk("rst_state", hz_state_o, 0);
        chk("rst_cnt", stall_cycles_o, 0);
        mdu_start_i = 1'b0;
        tick();
        hz_rst = 1'b1;
        // load-use on rs2
        ex_mem_rd_en = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
        @(negedge hz_clk);
        chk("lu_stall", stall_pipeline, 1);
        chk("lu_flush", flush_id_ex, 1);
        tick();
        chk("lu_state", hz_state_o, 1);
        chk("lu_cnt", stall_cycles_o, 1);
        @(negedge hz_clk);
        chk("lu2_stall", stall_pipeline, 0);
        chk("lu2_flush", flush_id_ex, 0);
        branch_flush_i = 1; #1;
        chk("lu2_brflush", flush_id_ex, 1);
        tick();
        clr();
        chk("lu_back_idle", hz_state_o, 0);
        // no false hazards
        ex_mem_rd_en = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
        @(negedge hz_clk);
        chk("rd0_stall", stall_pipeline, 0);
        ex_rd = 7; id_rs1 = 7; id_rs1_used = 0; #1;
        chk("unused_stall", stall_pipeline, 0);
        chk("unused_flush", flush_id_ex, 0);
        tick();
        clr();
        wdt_reset_i = 1;
        tick();
        wdt_reset_i = 0;
        chk("wdt_clr_cnt", stall_cycles_o, 0);
        // divide, start collides with load-use and a stray valid
        mdu_start_i = 1; div_valid_i = 1; ex_mem_rd_en = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
        @(negedge hz_clk);
        chk("mdu_start_stall", stall_pipeline, 1);
        chk("mdu_start_flush", flush_id_ex, 0);
        tick();
        clr();
        chk("mdu_state", hz_state_o, 2);
        branch_flush_i = 1;
        for (int i = 1; i <= 33; i++) begin
            div_valid_i = (i == 33);
            @(negedge hz_clk);
            chk("wait_stall", stall_pipeline, 1);
            chk("wait_noflush", flush_id_ex, 0);
            tick();
        end
        clr();
        chk("drain_state", hz_state_o, 3);
        @(negedge hz_clk);
        chk("drain_stall", stall_pipeline, 1);
        tick();
        chk("div_idle", hz_state_o, 0);
        chk("div_cnt", stall_cycles_o, 35);
        @(negedge hz_clk);
        chk("div_after_stall", stall_pipeline, 0);
        // watchdog mid-wait
        mdu_start_i = 1;
        tick();
        mdu_start_i = 0;
        repeat (11) tick();
        wdt_reset_i = 1;
        @(negedge hz_clk);
        chk("wdt_stall", stall_pipeline, 0);
        chk("wdt_timeout", mdu_timeout_o, 0);
        tick();
        wdt_reset_i = 0;
        chk("wdt_state", hz_state_o, 0);
        chk("wdt_cnt", stall_cycles_o, 0);
        // async reset mid-wait
        mdu_start_i = 1;
        tick();
        mdu_start_i = 0;
        repeat (3) tick();
        chk("pre_async_state", hz_state_o, 2);
        hz_rst = 0; #1;
        chk("async_stall", stall_pipeline, 0);
        chk("async_state", hz_state_o, 0);
        chk("async_cnt", stall_cycles_o, 0);
        tick();
        hz_rst = 1;
        // three 27-stall-cycle ops saturate a 6-bit counter at 63
        for (int k = 0; k < 3; k++) begin
            mdu_start_i = 1;
            tick();
            mdu_start_i = 0;
            repeat (24) tick();
            mult_valid_i = (k == 0); div_valid_i = (k == 1); rem_valid_i = (k == 2);
            tick();
            clr();
            chk("op_drain", hz_state_o, 3);
            tick();
        end
        chk("sat_cnt", stall_cycles_o, 63);
        chk("sat_state", hz_state_o, 0);
`ifdef HZ_MDU_TIMEOUT_EN
        mdu_start_i = 1;
        tick();
        mdu_start_i = 0;
        repeat (39) tick();
        @(negedge hz_clk);
        chk("to_pulse", mdu_timeout_o, 1);
        chk("to_stall", stall_pipeline, 1);
        tick();
        chk("to_idle", hz_state_o, 0);
        mdu_start_i = 1;
        tick();
        mdu_start_i = 0;
        repeat (39) tick();
        rem_valid_i = 1;
        @(negedge hz_clk);
        chk("to_valid_nopulse", mdu_timeout_o, 0);
        tick();
        rem_valid_i = 0;
        chk("to_valid_drain", hz_state_o, 3);
        tick();
`else
        mdu_start_i = 1;
        tick();
        mdu_start_i = 0;
        repeat (60) tick();
        @(negedge hz_clk);
        chk("long_wait_nopulse", mdu_timeout_o, 0);
        chk("long_wait_stall", stall_pipeline, 1);
        chk("long_wait_state", hz_state_o, 2);
        wdt_reset_i = 1;
        tick();
        wdt_reset_i = 0;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller that drives `stall_pipeline` into the forwarding unit and the IF/ID/EX pipeline registers.
- Detects load-use hazards, which forwarding cannot resolve, and inserts one bubble.
- Holds the pipeline for multi-cycle MUL/DIV/REM operations until the result is valid, plus one drain cycle.
- Sits in the ID stage, beside the forwarding unit; keeps a saturating stall-cycle performance counter.

Parameters:
- GPR_ADDR_WIDTH, 5, register address width (32 GPRs)
- STALL_CNT_WIDTH, 16, width of the stall performance counter
- MDU_TIMEOUT, 40, MDU_WAIT cycle limit; used only when HZ_MDU_TIMEOUT_EN is defined

Ports:
- hz_clk  input  1  clock; single clock domain
- hz_rst  input  1  asynchronous active-low reset
- wdt_reset_i  input  1  synchronous watchdog reset; highest priority after hz_rst
- id_rs1  input  GPR_ADDR_WIDTH  rs1 of the instruction in ID
- id_rs2  input  GPR_ADDR_WIDTH  rs2 of the instruction in ID
- id_rs1_used  input  1  ID instruction reads rs1
- id_rs2_used  input  1  ID instruction reads rs2
- ex_rd  input  GPR_ADDR_WIDTH  destination of the instruction in EX
- ex_mem_rd_en  input  1  instruction in EX is a load
- mdu_start_i  input  1  MUL/DIV/REM issued in EX this cycle
- mult_valid_i  input  1  multiplier result valid (1-cycle pulse)
- div_valid_i  input  1  divider result valid
- rem_valid_i  input  1  remainder result valid
- branch_flush_i  input  1  taken branch/jump redirect
- stall_pipeline  output  1  hold PC, IF/ID and forwarding ID/EX latches
- flush_id_ex  output  1  insert bubble into ID/EX
- hz_state_o  output  2  current FSM state
- stall_cycles_o  output  STALL_CNT_WIDTH  saturating count of stalled cycles
- mdu_timeout_o  output  1  1-cycle pulse when an MDU wait is aborted

Behaviour:
- Reset (hz_rst low):
  - state=IDLE.
  - stall_pipeline, flush_id_ex, mdu_timeout_o forced 0 regardless of inputs.
  - stall_cycles_o=0, hz_state_o=0.
- State encoding: IDLE=00, LU_STALL=01, MDU_WAIT=10, MDU_DRAIN=11. State is registered.
- stall_pipeline and flush_id_ex are Mealy outputs, valid in the same cycle as their inputs.
- load_use = ex_mem_rd_en && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
- IDLE, evaluated in priority order:
  - wdt_reset_i → stay IDLE, all outputs 0.
  - branch_flush_i → flush_id_ex=1, stall=0, stay IDLE.
  - mdu_start_i → stall=1, flush=0, next state MDU_WAIT.
  - load_use → stall=1, flush=1, next state LU_STALL.
  - Otherwise stall=0, flush=0.
- LU_STALL:
  - stall=0, flush=0; detection is suppressed for this cycle.
  - Next state IDLE.
  - The load is now in MEM; the dependency resolves via mem_wb forwarding.
  - branch_flush_i → flush=1.
- MDU_WAIT:
  - stall=1, flush=0.
  - branch_flush_i and mdu_start_i are ignored.
  - Any of mult_valid_i/div_valid_i/rem_valid_i → next state MDU_DRAIN.
  - A valid pulse arriving in the same cycle that mdu_start_i is accepted in IDLE is ignored.
- MDU_DRAIN:
  - stall=1 for exactly one cycle, covering result writeback; next state IDLE.
  - Further valid pulses are ignored.
- Stall latency:
  - MDU: cycles with stall=1 = (cycles from start to valid) + 1 drain cycle.
  - Load-use: exactly 1 cycle.
- stall_cycles_o increments on every cycle stall_pipeline=1 and saturates at all-ones (no wrap). It is cleared by hz_rst or wdt_reset_i.
- wdt_reset_i, any state: next state IDLE, counter cleared, stall=0, flush=0 in that cycle, mdu_timeout_o=0.
- Async reset asserted mid-MDU_WAIT: immediate IDLE, stall deasserts asynchronously.
- ex_rd=0 never triggers load-use.

Optional Feature:
- Macro: HZ_MDU_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(MDU_TIMEOUT+1) clears on MDU_WAIT entry and increments each cycle in MDU_WAIT.
  - If it reaches MDU_TIMEOUT with no valid pulse, next state is IDLE (no drain), and mdu_timeout_o pulses 1 in that same cycle, with stall=1.
  - Valid and timeout in the same cycle → valid wins (MDU_DRAIN, no timeout pulse).
- Not defined: MDU_WAIT waits indefinitely; mdu_timeout_o tied 0; no counter logic.

Test Plan:
- Load-use: ex_mem_rd_en=1, ex_rd=5, id_rs2=5, id_rs2_used=1 → stall=1, flush=1 that cycle; next cycle state=01, stall=0; stall_cycles_o=1.
- No false hazard:
  - ex_rd=0 with id_rs1=0 used → stall=0.
  - ex_rd=7 with id_rs1=7 but id_rs1_used=0 → stall=0.
- Divide: mdu_start_i at cycle 0, div_valid_i at cycle 33 → stall=1 for cycles 0..34 (35 cycles); state back to 00 at cycle 35; stall_cycles_o=35.
- Priority: mdu_start_i and load_use in the same cycle → MDU_WAIT, flush=0; branch_flush_i during MDU_WAIT → no flush.
- wdt_reset_i mid-MDU_WAIT, counter=12 → next cycle state=00, stall=0, stall_cycles_o=0; async hz_rst low mid-wait → outputs 0 immediately.
- With HZ_MDU_TIMEOUT_EN and MDU_TIMEOUT=40, no valid pulse → mdu_timeout_o=1 on the 40th MDU_WAIT cycle, then IDLE; a valid pulse on that same cycle → MDU_DRAIN, no timeout pulse.
